// File: rtl/ws2812_pkg.sv
// Shared types and helpers for the WS2812 frame serializer: state encoding,
// time-to-cycle conversion and a few reference GRB colour words.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_e;

  function automatic int ns_to_cyc(input int freq_mhz, input int t_ns);
    return (freq_mhz * t_ns) / 1000;
  endfunction

  function automatic int us_to_cyc(input int freq_mhz, input int t_us);
    return freq_mhz * t_us;
  endfunction

  // Colour words are GRB ordered, matching the order they go out on the wire.
  localparam logic [23:0] COLOUR_OFF   = 24'h000000;
  localparam logic [23:0] COLOUR_GREEN = 24'hFF0000;
  localparam logic [23:0] COLOUR_RED   = 24'h00FF00;
  localparam logic [23:0] COLOUR_BLUE  = 24'h0000FF;
  localparam logic [23:0] COLOUR_WHITE = 24'hFFFFFF;

endpackage

// File: rtl/ws2812_bit_timer.sv
// Free-running bit-period counter. It looks one cycle ahead so the parent can
// register the line: signal_next is the level for the following cycle.
module ws2812_bit_timer #(
  parameter int PERIOD_CYC = 125,
  parameter int T1H_CYC    = 90,
  parameter int T0H_CYC    = 35
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic bit_val,
  output logic signal_next,
  output logic bit_end
);

  localparam int CW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [CW-1:0] LAST_CYC = CW'(PERIOD_CYC - 1);
  localparam logic [CW-1:0] T1H      = CW'(T1H_CYC);
  localparam logic [CW-1:0] T0H      = CW'(T0H_CYC);

  logic [CW-1:0] cyc;
  logic [CW-1:0] cyc_next;

  // NOTE: every output of an always_comb gets a value on every path, here by
  // straight-line assignment, so no latch can be inferred.
  always_comb begin
    bit_end  = (cyc == LAST_CYC);
    cyc_next = cyc + CW'(1);
    if (start || bit_end) begin
      cyc_next = '0;
    end
    // bit_val is the bit that owns cyc_next, supplied by the parent.
    signal_next = (cyc_next < (bit_val ? T1H : T0H));
  end

  // NOTE: sequential state uses non-blocking assignment so each flop samples
  // the pre-edge values independent of evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc <= '0;
    end else begin
      cyc <= cyc_next;
    end
  end

endmodule

// File: rtl/ws2812_frame_serializer.sv
// WS2812 one-wire frame serializer: word 0 first, MSB first, then a low latch gap.
// Optional replay of the last frame when idle: define WS2812_AUTO_REFRESH_EN.
module ws2812_frame_serializer
  import ws2812_pkg::*;
#(
  parameter int SYS_FREQ_MHZ = 100,
  parameter int PERIOD_NS    = 1250,
  parameter int T1H_NS       = 900,
  parameter int T0H_NS       = 350,
  parameter int LATCH_US     = 80,
  parameter int NUM_WORDS    = 64,
  parameter int WORD_BITS    = 24
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_WORDS*WORD_BITS-1:0] bits,
  input  logic                           frame_valid,
  output logic                           frame_ready,
  output logic                           signal,
  output logic                           busy,
  output logic                           frame_done
);

  localparam int PERIOD_CYC = ns_to_cyc(SYS_FREQ_MHZ, PERIOD_NS);
  localparam int T1H_CYC    = ns_to_cyc(SYS_FREQ_MHZ, T1H_NS);
  localparam int T0H_CYC    = ns_to_cyc(SYS_FREQ_MHZ, T0H_NS);
  localparam int LATCH_CYC  = us_to_cyc(SYS_FREQ_MHZ, LATCH_US);
  localparam int NUM_BITS   = NUM_WORDS * WORD_BITS;
  localparam int IW         = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int LW         = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;

  if (T1H_CYC >= PERIOD_CYC || T0H_CYC == 0) begin : g_bad_timing
    $error("ws2812_frame_serializer: need T1H_CYC < PERIOD_CYC and T0H_CYC > 0");
  end

  state_e              state;
  state_e              state_next;
  logic [NUM_BITS-1:0] ordered_in;
  logic [NUM_BITS-1:0] shadow;
  logic [IW-1:0]       bit_idx;
  logic [LW-1:0]       latch_cnt;
  logic                accept;
  logic                refresh;
  logic                start;
  logic                bit_val;
  logic                signal_next;
  logic                bit_end;
  logic                last_bit;
  logic                latch_last;

  // Reorder the frame into wire order: bit NUM_BITS-1 is word 0 bit 23, then
  // descending. The shadow then only ever rotates left by one.
  always_comb begin
    ordered_in = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      for (int b = 0; b < WORD_BITS; b++) begin
        ordered_in[NUM_BITS - (k + 1) * WORD_BITS + b] = bits[k * WORD_BITS + b];
      end
    end
  end

  assign accept = (state == IDLE) && frame_valid;

`ifdef WS2812_AUTO_REFRESH_EN
  logic have_frame;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      have_frame <= 1'b0;
    end else if (accept) begin
      have_frame <= 1'b1;
    end
  end

  assign refresh = (state == IDLE) && !frame_valid && have_frame;
`else
  assign refresh = 1'b0;
`endif

  assign start      = accept || refresh;
  assign last_bit   = (bit_idx == IW'(NUM_BITS - 1));
  assign latch_last = (latch_cnt == LW'(LATCH_CYC - 1));

  // Bit that owns the next line cycle: a fresh frame's first bit on accept,
  // the upcoming shadow bit at a bit boundary, otherwise the current one.
  always_comb begin
    bit_val = shadow[NUM_BITS-1];
    if (accept) begin
      bit_val = ordered_in[NUM_BITS-1];
    end else if ((state == SEND) && bit_end) begin
      bit_val = shadow[NUM_BITS-2];
    end
  end

  ws2812_bit_timer #(
    .PERIOD_CYC (PERIOD_CYC),
    .T1H_CYC    (T1H_CYC),
    .T0H_CYC    (T0H_CYC)
  ) u_bit_timer (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bit_val     (bit_val),
    .signal_next (signal_next),
    .bit_end     (bit_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = SEND;
      SEND:    if (bit_end && last_bit) state_next = LATCH;
      LATCH:   if (latch_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    frame_ready = (state == IDLE);
    busy        = (state == SEND) || (state == LATCH);
    frame_done  = (state == LATCH) && latch_last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      signal    <= 1'b0;
      bit_idx   <= '0;
      latch_cnt <= '0;
    end else begin
      signal <= (state_next == SEND) && signal_next;
      if (start) begin
        bit_idx <= '0;
      end else if ((state == SEND) && bit_end) begin
        bit_idx <= bit_idx + IW'(1);
      end
      latch_cnt <= (state == LATCH) ? latch_cnt + LW'(1) : '0;
    end
  end

  // NOTE: the shadow is plain flops, not a RAM, so it can take the reset; a
  // cleared shadow means nothing stale survives a reset.
  // A full frame is NUM_BITS rotations, which restores the original order
  // for a later replay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
    end else if (accept) begin
      shadow <= ordered_in;
    end else if ((state == SEND) && bit_end) begin
      shadow <= {shadow[NUM_BITS-2:0], shadow[NUM_BITS-1]};
    end
  end

endmodule
